example_rtl_dma64_loader: RTL

//  Load stage directly downstream of the DMA64 read channel. Takes a base word index
//  and a beat count from configuration, then issues bounded read bursts on
//  dma_read_ctrl. Buffers the returned 64-bit beats in a FIFO and presents them as a

---
 rtl/example_rtl_dma64_loader.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/example_rtl_dma64_loader.sv
// DMA64 read-side loader: issues bounded read bursts, buffers returned beats, streams them out.
// Optional debug counters are enabled with the DMA64_LOADER_DEBUG_EN macro.
module example_rtl_dma64_loader #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned BURST_MAX  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        conf_done,
  input  logic [31:0] conf_info_base,
  input  logic [31:0] conf_info_len,
  output logic        dma_read_ctrl_valid,
  input  logic        dma_read_ctrl_ready,
  output logic [31:0] dma_read_ctrl_data_index,
  output logic [31:0] dma_read_ctrl_data_length,
  output logic [2:0]  dma_read_ctrl_data_size,
  input  logic        dma_read_chnl_valid,
  output logic        dma_read_chnl_ready,
  input  logic [63:0] dma_read_chnl_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_last,
  output logic        load_done,
  output logic [31:0] debug
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_XFER  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               conf_prev_q;
  logic [31:0]        idx_q, idx_d;
  logic [31:0]        rem_q, rem_d;
  logic [31:0]        burst_left_q, burst_left_d;
  logic               ctrl_valid_q, ctrl_valid_d;
  logic [31:0]        ctrl_index_q, ctrl_index_d;
  logic [31:0]        ctrl_length_q, ctrl_length_d;
  logic               load_done_q, load_done_d;

  logic [63:0]        fifo_data_q [FIFO_DEPTH];
  logic               fifo_last_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               chnl_ready_q, chnl_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [63:0]        out_data_q, out_data_d;
  logic               out_last_q, out_last_d;

  logic               conf_rise_c;
  logic               push_c;
  logic               pop_c;
  logic               last_tag_c;
  logic               head_bypass_c;
  logic [CNT_W-1:0]   count_after_pop_c;
  logic [31:0]        free_c;
  logic [31:0]        burst_c;

  // Handshakes and burst sizing; free space counts the pop retiring at this edge.
  always_comb begin
    conf_rise_c       = conf_done & ~conf_prev_q;
    push_c            = (state_q == S_XFER) & dma_read_chnl_valid & chnl_ready_q;
    pop_c             = out_valid_q & out_ready;
    last_tag_c        = (rem_q == 32'd1);
    count_after_pop_c = count_q - CNT_W'(pop_c);
    free_c            = 32'(FIFO_DEPTH) - 32'(count_after_pop_c);
    burst_c           = rem_q;
    if (burst_c > 32'(BURST_MAX)) begin
      burst_c = 32'(BURST_MAX);
    end
    if (burst_c > free_c) begin
      burst_c = free_c;
    end
  end

  // Control FSM next-state and request outputs.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    rem_d         = rem_q;
    burst_left_d  = burst_left_q;
    ctrl_valid_d  = ctrl_valid_q;
    ctrl_index_d  = ctrl_index_q;
    ctrl_length_d = ctrl_length_q;
    load_done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (conf_rise_c) begin
          idx_d   = conf_info_base;
          rem_d   = conf_info_len;
          state_d = (conf_info_len == 32'd0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (!ctrl_valid_q) begin
          if (burst_c != 32'd0) begin
            ctrl_valid_d  = 1'b1;
            ctrl_index_d  = idx_q;
            ctrl_length_d = burst_c;
          end
        end else if (dma_read_ctrl_ready) begin
          ctrl_valid_d = 1'b0;
          burst_left_d = ctrl_length_q;
          state_d      = S_XFER;
        end
      end
      S_XFER: begin
        if (push_c) begin
          burst_left_d = burst_left_q - 32'd1;
          rem_d        = rem_q - 32'd1;
          if (burst_left_q == 32'd1) begin
            if (rem_q == 32'd1) begin
              state_d = S_DRAIN;
            end else begin
              idx_d   = idx_q + ctrl_length_q;
              state_d = S_REQ;
            end
          end
        end
      end
      S_DRAIN: begin
        if (count_q == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        load_done_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO pointers and registered head; bypass when the head slot is written this cycle.
  always_comb begin
    wr_ptr_d      = wr_ptr_q + PTR_W'(push_c);
    rd_ptr_d      = rd_ptr_q + PTR_W'(pop_c);
    count_d       = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    head_bypass_c = push_c & (wr_ptr_q == rd_ptr_d);
    out_valid_d   = (count_d != '0);
    chnl_ready_d  = (count_d != CNT_W'(FIFO_DEPTH));
    out_data_d    = head_bypass_c ? dma_read_chnl_data : fifo_data_q[rd_ptr_d];
    out_last_d    = head_bypass_c ? last_tag_c : fifo_last_q[rd_ptr_d];
    if (!out_valid_d) begin
      out_data_d = '0;
      out_last_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      conf_prev_q   <= 1'b0;
      idx_q         <= '0;
      rem_q         <= '0;
      burst_left_q  <= '0;
      ctrl_valid_q  <= 1'b0;
      ctrl_index_q  <= '0;
      ctrl_length_q <= '0;
      load_done_q   <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      chnl_ready_q  <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_last_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      conf_prev_q   <= conf_done;
      idx_q         <= idx_d;
      rem_q         <= rem_d;
      burst_left_q  <= burst_left_d;
      ctrl_valid_q  <= ctrl_valid_d;
      ctrl_index_q  <= ctrl_index_d;
      ctrl_length_q <= ctrl_length_d;
      load_done_q   <= load_done_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      chnl_ready_q  <= chnl_ready_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_last_q    <= out_last_d;
    end
  end

  // Beat storage carries no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_data_q[wr_ptr_q] <= dma_read_chnl_data;
      fifo_last_q[wr_ptr_q] <= last_tag_c;
    end
  end

`ifdef DMA64_LOADER_DEBUG_EN
  logic [15:0] beats_out_q, beats_out_d;

  // Popped-beat counter, cleared on job start and saturating.
  always_comb begin
    beats_out_d = beats_out_q;
    if ((state_q == S_IDLE) && conf_rise_c) begin
      beats_out_d = '0;
    end else if (pop_c && (beats_out_q != 16'hFFFF)) begin
      beats_out_d = beats_out_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beats_out_q <= '0;
    end else begin
      beats_out_q <= beats_out_d;
    end
  end

  assign debug = {3'(state_q), 5'b0, 8'(count_q), beats_out_q};
`else
  assign debug = 32'd0;
`endif

  assign dma_read_ctrl_valid       = ctrl_valid_q;
  assign dma_read_ctrl_data_index  = ctrl_index_q;
  assign dma_read_ctrl_data_length = ctrl_length_q;
  assign dma_read_ctrl_data_size   = 3'b011;
  assign dma_read_chnl_ready       = chnl_ready_q;
  assign out_valid                 = out_valid_q;
  assign out_data                  = out_data_q;
  assign out_last                  = out_last_q;
  assign load_done                 = load_done_q;

endmodule
